// File: rtl/mem_wb_if.sv
// Execution-to-memory/write-back bundle: instruction inputs, load stall and
// register-file / flag write-back outputs.
interface mem_wb_if #(
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
);
    logic              valid_ex;
    logic [4:0]        op_ex;
    logic [RD_W-1:0]   rd_ex;
    logic [DATA_W-1:0] ans_ex;
    logic [DATA_W-1:0] DM_data;
    logic [3:0]        flag_ex;
    logic              stall_req;
    logic              wb_en;
    logic [RD_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        flag_wb;

    modport master (
        output valid_ex, op_ex, rd_ex, ans_ex, DM_data, flag_ex,
        input  stall_req, wb_en, wb_addr, wb_data, flag_wb
    );

    modport slave (
        input  valid_ex, op_ex, rd_ex, ans_ex, DM_data, flag_ex,
        output stall_req, wb_en, wb_addr, wb_data, flag_wb
    );
endinterface

// File: rtl/mem_writeback_stage.sv
// Memory / write-back stage: data-memory store and two-cycle load through an
// internal synchronous RAM, register-file write port and architectural flags.
module mem_writeback_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    mem_wb_if.slave    bus
);
    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    localparam logic [4:0] OP_STORE = 5'b10100;
    localparam logic [4:0] OP_LOAD  = 5'b10101;
    // Bit n set when opcode n writes its ALU result back to the register file.
    localparam logic [31:0] ALU_WB_MASK = 32'h0E40_F7F7;

    state_t            state_reg;
    logic              wb_en_reg;
    logic [RD_W-1:0]   wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic [3:0]        flag_wb_reg;
    logic [RD_W-1:0]   rd_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              accept;
    logic              is_store;
    logic              is_load;
    logic              is_alu_wb;
    logic [ADDR_W-1:0] addr;

    assign accept    = (state_reg == IDLE) && bus.valid_ex;
    assign is_store  = (bus.op_ex == OP_STORE);
    assign is_load   = (bus.op_ex == OP_LOAD);
    assign is_alu_wb = ALU_WB_MASK[bus.op_ex];
    assign addr      = bus.ans_ex[ADDR_W-1:0];

    // Reset suppresses the stall so upstream is never frozen while we are being cleared.
    assign bus.stall_req = !reset && accept && is_load;

    // RAM kept free of reset so it maps onto block memory; read is registered.
    always_ff @(posedge clk) begin
        if (!reset && accept && is_store) begin
            mem[addr] <= bus.DM_data;
        end
        if (accept && is_load) begin
            rdata_reg <= mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            wb_en_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
            flag_wb_reg <= 4'b0000;
            rd_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wb_en_reg <= 1'b0;
                    if (bus.valid_ex) begin
                        flag_wb_reg <= bus.flag_ex;
                        if (is_load) begin
                            rd_reg    <= bus.rd_ex;
                            state_reg <= LOAD_WAIT;
                        end else if (is_alu_wb) begin
                            wb_en_reg   <= 1'b1;
                            wb_addr_reg <= bus.rd_ex;
                            wb_data_reg <= bus.ans_ex;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // Upstream is still presenting the held load; nothing is accepted here.
                    wb_en_reg   <= 1'b1;
                    wb_addr_reg <= rd_reg;
                    wb_data_reg <= rdata_reg;
                    state_reg   <= IDLE;
                end
                default: begin
                    wb_en_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.wb_en   = wb_en_reg;
    assign bus.wb_addr = wb_addr_reg;
    assign bus.wb_data = wb_data_reg;
    assign bus.flag_wb = flag_wb_reg;
endmodule
